// File: rtl/mem_line_responder_if.sv
// Request/response bus between the core's shared L1D/L1I memory port and the
// cache-line backing store. The master side is the initiator (cache), the
// slave side is the responder.
interface mem_line_responder_if #(
    parameter int M_WIDTH            = 32,
    parameter int CL_BITS            = 128,
    parameter int LG_MEM_TAG_ENTRIES = 2
);
    logic                          mem_req_valid;
    logic [M_WIDTH-1:0]            mem_req_addr;
    logic [CL_BITS-1:0]            mem_req_store_data;
    logic [LG_MEM_TAG_ENTRIES-1:0] mem_req_tag;
    logic [3:0]                    mem_req_opcode;
    logic                          mem_rsp_valid;
    logic [CL_BITS-1:0]            mem_rsp_load_data;
    logic [LG_MEM_TAG_ENTRIES-1:0] mem_rsp_tag;

    modport master (
        output mem_req_valid, mem_req_addr, mem_req_store_data, mem_req_tag, mem_req_opcode,
        input  mem_rsp_valid, mem_rsp_load_data, mem_rsp_tag
    );

    modport slave (
        input  mem_req_valid, mem_req_addr, mem_req_store_data, mem_req_tag, mem_req_opcode,
        output mem_rsp_valid, mem_rsp_load_data, mem_rsp_tag
    );
endinterface

// File: rtl/mem_line_responder.sv
// Cache-line backing store that answers one line request at a time after a
// fixed latency. Loads return a whole line, stores commit a whole line, and a
// backdoor init port preloads program/data images at any time.
module mem_line_responder #(
    parameter int M_WIDTH            = 32,
    parameter int CL_BITS            = 128,
    parameter int LG_MEM_TAG_ENTRIES = 2,
    parameter int LG_LINES           = 12,
    parameter int LATENCY            = 4
) (
    input  logic                clk,
    input  logic                reset,
    mem_line_responder_if.slave memBus,
    input  logic                init_valid,
    input  logic [M_WIDTH-1:0]  init_addr,
    input  logic [CL_BITS-1:0]  init_data,
    output logic                busy,
    output logic [31:0]         load_count,
    output logic [31:0]         store_count,
    output logic                bad_opcode
);
    localparam int LGB = $clog2(CL_BITS / 8);
    localparam int DEPTH = 1 << LG_LINES;
    localparam logic [3:0] OP_LOAD  = 4'd4;
    localparam logic [3:0] OP_STORE = 4'd7;
    localparam logic [7:0] CNT_INIT = 8'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t                        r_state;
    state_t                        w_nextState;
    logic                          w_capture;
    logic                          w_enterResp;
    logic [CL_BITS-1:0]            r_mem [0:DEPTH-1];
    logic [LG_LINES-1:0]           w_reqIdx;
    logic [LG_LINES-1:0]           w_initIdx;
    logic [LG_LINES-1:0]           r_capIdx;
    logic [LG_MEM_TAG_ENTRIES-1:0] r_capTag;
    logic [3:0]                    r_capOp;
    logic [CL_BITS-1:0]            r_capData;
    logic [7:0]                    r_cnt;
    logic [LG_LINES-1:0]           w_actIdx;
    logic [LG_MEM_TAG_ENTRIES-1:0] w_actTag;
    logic [3:0]                    w_actOp;
    logic [CL_BITS-1:0]            w_actData;
    logic [CL_BITS-1:0]            r_rspData;
    logic [LG_MEM_TAG_ENTRIES-1:0] r_rspTag;
    logic [31:0]                   r_loadCount;
    logic [31:0]                   r_storeCount;
    logic                          r_badOp;
    logic                          w_unused_addr;

    // Offset bits and bits above the index are deliberately dropped so addresses alias.
    assign w_reqIdx      = memBus.mem_req_addr[LGB+LG_LINES-1:LGB];
    assign w_initIdx     = init_addr[LGB+LG_LINES-1:LGB];
    assign w_unused_addr = ^{memBus.mem_req_addr, init_addr};

    // With LATENCY=1 the capture edge is also the response edge, so the live
    // request fields must feed the response actions directly.
    assign w_actIdx  = (r_state == IDLE) ? w_reqIdx                  : r_capIdx;
    assign w_actTag  = (r_state == IDLE) ? memBus.mem_req_tag        : r_capTag;
    assign w_actOp   = (r_state == IDLE) ? memBus.mem_req_opcode     : r_capOp;
    assign w_actData = (r_state == IDLE) ? memBus.mem_req_store_data : r_capData;

    assign memBus.mem_rsp_valid     = (r_state == RESP);
    assign memBus.mem_rsp_load_data = r_rspData;
    assign memBus.mem_rsp_tag       = r_rspTag;
    assign busy                     = (r_state != IDLE);
    assign load_count               = r_loadCount;
    assign store_count              = r_storeCount;
    assign bad_opcode               = r_badOp;

    // State register for the request sequencer.
    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_nextState;
    end

    // Next-state decode; also flags the capture edge and the response edge.
    always_comb begin
        w_nextState = r_state;
        w_capture   = 1'b0;
        w_enterResp = 1'b0;
        case (r_state)
            IDLE: begin
                if (memBus.mem_req_valid) begin
                    w_capture = 1'b1;
                    if (LATENCY == 1) begin
                        w_nextState = RESP;
                        w_enterResp = 1'b1;
                    end else begin
                        w_nextState = WAIT;
                    end
                end
            end
            WAIT: begin
                if (r_cnt <= 8'd1) begin
                    w_nextState = RESP;
                    w_enterResp = 1'b1;
                end
            end
            RESP:    w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // Request capture, latency countdown and registered response/statistics.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_capIdx     <= '0;
            r_capTag     <= '0;
            r_capOp      <= '0;
            r_capData    <= '0;
            r_cnt        <= '0;
            r_rspData    <= '0;
            r_rspTag     <= '0;
            r_loadCount  <= '0;
            r_storeCount <= '0;
            r_badOp      <= 1'b0;
        end else begin
            if (w_capture) begin
                r_capIdx  <= w_reqIdx;
                r_capTag  <= memBus.mem_req_tag;
                r_capOp   <= memBus.mem_req_opcode;
                r_capData <= memBus.mem_req_store_data;
                r_cnt     <= CNT_INIT;
            end else if (r_state == WAIT) begin
                r_cnt <= r_cnt - 8'd1;
            end
            if (w_enterResp) begin
                r_rspTag <= w_actTag;
                case (w_actOp)
                    OP_LOAD: begin
                        r_rspData   <= r_mem[w_actIdx];
                        r_loadCount <= r_loadCount + 32'd1;
                    end
                    OP_STORE: begin
                        r_rspData    <= '0;
                        r_storeCount <= r_storeCount + 32'd1;
                    end
                    default: begin
                        r_rspData <= '0;
                        r_badOp   <= 1'b1;
                    end
                endcase
            end
        end
    end

    // Line array: init writes first so a same-line store commit overrides it;
    // contents are intentionally not cleared by reset.
    always_ff @(posedge clk) begin
        if (init_valid)
            r_mem[w_initIdx] <= init_data;
        if (w_enterResp && !reset && (w_actOp == OP_STORE))
            r_mem[w_actIdx] <= w_actData;
    end
endmodule

// File: tb/tb_mem_line_responder.sv
// Directed bench for mem_line_responder: a LATENCY=4 instance for the main
// load/store/alias/reset scenarios and a LATENCY=1 instance for back-to-back.
module tb_mem_line_responder;
    logic         clk;
    logic         reset;
    logic         init4Valid, init1Valid;
    logic [31:0]  init4Addr, init1Addr;
    logic [127:0] init4Data, init1Data;
    logic         busy4, busy1;
    logic [31:0]  loadCount4, storeCount4, loadCount1, storeCount1;
    logic         badOp4, badOp1;
    int           compared;
    int           mismatched;
    int           lat;
    int           seen;

    mem_line_responder_if #(.M_WIDTH(32), .CL_BITS(128), .LG_MEM_TAG_ENTRIES(2)) bus4 ();
    mem_line_responder_if #(.M_WIDTH(32), .CL_BITS(128), .LG_MEM_TAG_ENTRIES(2)) bus1 ();

    mem_line_responder #(.M_WIDTH(32), .CL_BITS(128), .LG_MEM_TAG_ENTRIES(2),
                         .LG_LINES(12), .LATENCY(4)) dut4 (
        .clk(clk), .reset(reset), .memBus(bus4.slave),
        .init_valid(init4Valid), .init_addr(init4Addr), .init_data(init4Data),
        .busy(busy4), .load_count(loadCount4), .store_count(storeCount4), .bad_opcode(badOp4)
    );

    mem_line_responder #(.M_WIDTH(32), .CL_BITS(128), .LG_MEM_TAG_ENTRIES(2),
                         .LG_LINES(12), .LATENCY(1)) dut1 (
        .clk(clk), .reset(reset), .memBus(bus1.slave),
        .init_valid(init1Valid), .init_addr(init1Addr), .init_data(init1Data),
        .busy(busy1), .load_count(loadCount1), .store_count(storeCount1), .bad_opcode(badOp1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [127:0] observed, input logic [127:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h expected %h", name, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request on the LATENCY=4 instance from an idle cycle and wait
    // for its response; optionally fire a backdoor init at cycle T+injCycle.
    task automatic applyStimulus(input logic [3:0] op, input logic [31:0] addr, input logic [1:0] tag,
                                 input logic [127:0] data, input int injCycle,
                                 input logic [31:0] injAddr, input logic [127:0] injData);
        tick();
        bus4.mem_req_valid      = 1'b1;
        bus4.mem_req_opcode     = op;
        bus4.mem_req_addr       = addr;
        bus4.mem_req_tag        = tag;
        bus4.mem_req_store_data = data;
        lat = 0;
        do begin
            tick();
            lat++;
            init4Valid = (lat == injCycle);
            init4Addr  = injAddr;
            init4Data  = injData;
        end while (!bus4.mem_rsp_valid && lat < 20);
        init4Valid         = 1'b0;
        bus4.mem_req_valid = 1'b0;
        checkOutput("latency", 128'(lat), 128'd4);
        checkOutput("rspValid", 128'(bus4.mem_rsp_valid), 128'd1);
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        reset      = 1'b1;
        init4Valid = 1'b0; init4Addr = '0; init4Data = '0;
        init1Valid = 1'b0; init1Addr = '0; init1Data = '0;
        bus4.mem_req_valid = 1'b0; bus4.mem_req_addr = '0; bus4.mem_req_store_data = '0;
        bus4.mem_req_tag = '0; bus4.mem_req_opcode = '0;
        bus1.mem_req_valid = 1'b0; bus1.mem_req_addr = '0; bus1.mem_req_store_data = '0;
        bus1.mem_req_tag = '0; bus1.mem_req_opcode = '0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        $display("[TB] reset state");
        checkOutput("rstRspValid", 128'(bus4.mem_rsp_valid), 128'd0);
        checkOutput("rstRspData", bus4.mem_rsp_load_data, 128'd0);
        checkOutput("rstRspTag", 128'(bus4.mem_rsp_tag), 128'd0);
        checkOutput("rstBusy", 128'(busy4), 128'd0);
        checkOutput("rstLoadCount", 128'(loadCount4), 128'd0);
        checkOutput("rstStoreCount", 128'(storeCount4), 128'd0);
        checkOutput("rstBadOp", 128'(badOp4), 128'd0);

        $display("[TB] init + load with offset");
        init4Valid = 1'b1; init4Addr = 32'h100; init4Data = {4{32'hA5A5A5A5}};
        tick();
        init4Valid = 1'b0;
        applyStimulus(4'd4, 32'h104, 2'd1, '0, 0, '0, '0);
        checkOutput("load1Data", bus4.mem_rsp_load_data, {4{32'hA5A5A5A5}});
        checkOutput("load1Tag", 128'(bus4.mem_rsp_tag), 128'd1);
        checkOutput("load1Count", 128'(loadCount4), 128'd1);
        checkOutput("load1Busy", 128'(busy4), 128'd1);

        $display("[TB] store then load");
        applyStimulus(4'd7, 32'h200, 2'd2, {4{32'hDEADBEEF}}, 0, '0, '0);
        checkOutput("storeData", bus4.mem_rsp_load_data, 128'd0);
        checkOutput("storeTag", 128'(bus4.mem_rsp_tag), 128'd2);
        checkOutput("storeCount", 128'(storeCount4), 128'd1);
        tick();
        checkOutput("holdData", bus4.mem_rsp_load_data, 128'd0);
        checkOutput("holdValid", 128'(bus4.mem_rsp_valid), 128'd0);
        checkOutput("idleBusy", 128'(busy4), 128'd0);
        applyStimulus(4'd4, 32'h200, 2'd3, '0, 0, '0, '0);
        checkOutput("load2Data", bus4.mem_rsp_load_data, {4{32'hDEADBEEF}});
        checkOutput("load2Tag", 128'(bus4.mem_rsp_tag), 128'd3);

        $display("[TB] illegal opcode");
        applyStimulus(4'd9, 32'h200, 2'd1, {4{32'h01234567}}, 0, '0, '0);
        checkOutput("badData", bus4.mem_rsp_load_data, 128'd0);
        checkOutput("badTag", 128'(bus4.mem_rsp_tag), 128'd1);
        checkOutput("badFlag", 128'(badOp4), 128'd1);
        checkOutput("badLoadCount", 128'(loadCount4), 128'd2);
        checkOutput("badStoreCount", 128'(storeCount4), 128'd1);
        applyStimulus(4'd4, 32'h200, 2'd0, '0, 0, '0, '0);
        checkOutput("badMemKept", bus4.mem_rsp_load_data, {4{32'hDEADBEEF}});
        checkOutput("badSticky", 128'(badOp4), 128'd1);

        $display("[TB] address aliasing");
        applyStimulus(4'd7, 32'h10000, 2'd2, {4{32'h77777777}}, 0, '0, '0);
        applyStimulus(4'd4, 32'h00000, 2'd3, '0, 0, '0, '0);
        checkOutput("aliasData", bus4.mem_rsp_load_data, {4{32'h77777777}});
        checkOutput("aliasLoadCount", 128'(loadCount4), 128'd4);

        $display("[TB] init vs store same edge, init before pending load");
        applyStimulus(4'd7, 32'h300, 2'd1, {4{32'hCCCCCCCC}}, 3, 32'h300, {4{32'hBBBBBBBB}});
        applyStimulus(4'd4, 32'h300, 2'd2, '0, 0, '0, '0);
        checkOutput("storeWinsData", bus4.mem_rsp_load_data, {4{32'hCCCCCCCC}});
        applyStimulus(4'd4, 32'h500, 2'd3, '0, 2, 32'h508, {4{32'h99999999}});
        checkOutput("initVisibleData", bus4.mem_rsp_load_data, {4{32'h99999999}});
        checkOutput("storeCount3", 128'(storeCount4), 128'd3);

        $display("[TB] LATENCY=1 back-to-back");
        init1Valid = 1'b1; init1Addr = 32'h40; init1Data = {4{32'h12345678}};
        tick();
        init1Valid = 1'b0;
        bus1.mem_req_valid = 1'b1; bus1.mem_req_opcode = 4'd4; bus1.mem_req_addr = 32'h40;
        bus1.mem_req_tag = 2'd1;
        tick();
        checkOutput("b2bValid1", 128'(bus1.mem_rsp_valid), 128'd1);
        checkOutput("b2bBusy1", 128'(busy1), 128'd1);
        checkOutput("b2bData1", bus1.mem_rsp_load_data, {4{32'h12345678}});
        checkOutput("b2bTag1", 128'(bus1.mem_rsp_tag), 128'd1);
        bus1.mem_req_opcode = 4'd7; bus1.mem_req_tag = 2'd2; bus1.mem_req_store_data = {4{32'h55555555}};
        tick();
        checkOutput("b2bValid2", 128'(bus1.mem_rsp_valid), 128'd0);
        checkOutput("b2bBusy2", 128'(busy1), 128'd0);
        tick();
        bus1.mem_req_valid = 1'b0;
        checkOutput("b2bValid3", 128'(bus1.mem_rsp_valid), 128'd1);
        checkOutput("b2bBusy3", 128'(busy1), 128'd1);
        checkOutput("b2bTag3", 128'(bus1.mem_rsp_tag), 128'd2);
        checkOutput("b2bData3", bus1.mem_rsp_load_data, 128'd0);
        checkOutput("b2bStoreCount", 128'(storeCount1), 128'd1);
        checkOutput("b2bLoadCount", 128'(loadCount1), 128'd1);
        tick();
        checkOutput("b2bValid4", 128'(bus1.mem_rsp_valid), 128'd0);
        checkOutput("b2bBusy4", 128'(busy1), 128'd0);
        bus1.mem_req_valid = 1'b1; bus1.mem_req_opcode = 4'd4; bus1.mem_req_tag = 2'd3;
        tick();
        bus1.mem_req_valid = 1'b0;
        checkOutput("b2bReload", bus1.mem_rsp_load_data, {4{32'h55555555}});

        $display("[TB] reset during store");
        tick();
        tick();
        bus4.mem_req_valid = 1'b1; bus4.mem_req_opcode = 4'd7; bus4.mem_req_addr = 32'h100;
        bus4.mem_req_tag = 2'd3; bus4.mem_req_store_data = {4{32'h11111111}};
        seen = 0;
        tick();
        if (bus4.mem_rsp_valid) seen++;
        tick();
        if (bus4.mem_rsp_valid) seen++;
        reset = 1'b1;
        bus4.mem_req_valid = 1'b0;
        tick();
        reset = 1'b0;
        checkOutput("midRstValid", 128'(bus4.mem_rsp_valid), 128'd0);
        checkOutput("midRstData", bus4.mem_rsp_load_data, 128'd0);
        checkOutput("midRstTag", 128'(bus4.mem_rsp_tag), 128'd0);
        checkOutput("midRstBusy", 128'(busy4), 128'd0);
        checkOutput("midRstLoadCount", 128'(loadCount4), 128'd0);
        checkOutput("midRstStoreCount", 128'(storeCount4), 128'd0);
        checkOutput("midRstBadOp", 128'(badOp4), 128'd0);
        repeat (6) begin
            tick();
            if (bus4.mem_rsp_valid) seen++;
        end
        checkOutput("midRstNoRsp", 128'(seen), 128'd0);
        applyStimulus(4'd4, 32'h100, 2'd2, '0, 0, '0, '0);
        checkOutput("midRstMemKept", bus4.mem_rsp_load_data, {4{32'hA5A5A5A5}});
        checkOutput("midRstStoreCount2", 128'(storeCount4), 128'd0);
        checkOutput("midRstLoadCount2", 128'(loadCount4), 128'd1);

        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
